// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_adder_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder.
interface serial_adder_ctrl_if
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder built from two half_adder_a cells; the shared bit-slice
// of the serial adder.
module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);

   logic w_s0;
   logic w_c0;
   logic w_c1;

   half_adder_a u_ha0 (
      .i_a     (i_a),
      .i_b     (i_b),
      .o_sum   (w_s0),
      .o_carry (w_c0)
   );

   half_adder_a u_ha1 (
      .i_a     (w_s0),
      .i_b     (i_cin),
      .o_sum   (o_sum),
      .o_carry (w_c1)
   );

   assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder_a.sv
// One-bit half adder cell.
module half_adder_a (
   input  logic i_a,
   input  logic i_b,
   output logic o_sum,
   output logic o_carry
);

   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full_adder cell is reused LSB-first, one bit per
// clock, with the carry held in a flip-flop between cycles.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_ctrl_if.slave  bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_sr;
   logic             r_carry;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_load;
   logic             w_step;
   logic             w_last;
   logic             w_bitSum;
   logic             w_bitCarry;
   logic [WIDTH-1:0] w_srNext;

   full_adder u_fa (
      .i_a    (r_sa[0]),
      .i_b    (r_sb[0]),
      .i_cin  (r_carry),
      .o_sum  (w_bitSum),
      .o_cout (w_bitCarry)
   );

   assign w_srNext = {w_bitSum, r_sr[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A start seen in DONE is accepted exactly like one seen in IDLE.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_nextState = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (r_cnt == LAST_BIT) begin
               w_last      = 1'b1;
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_nextState = ST_RUN;
            end else begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sa    <= '0;
         r_sb    <= '0;
         r_sr    <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_load) begin
         r_sa    <= bus.a;
         r_sb    <= bus.b;
         r_carry <= bus.cin;
         r_cnt   <= '0;
      end else if (w_step) begin
         r_sa    <= r_sa >> 1;
         r_sb    <= r_sb >> 1;
         r_sr    <= w_srNext;
         r_carry <= w_bitCarry;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_sum  <= w_srNext;
            r_cout <= w_bitCarry;
         end
      end
   end

   assign bus.busy = (r_state == ST_RUN);
   assign bus.done = (r_state == ST_DONE);
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;

endmodule
